if_id_hazard_reg: RTL and testbench

IF/ID pipeline register with hazard control for the 5-stage pipelined CPU. It latches the fetched instruction and PC+1 from the fetch stage and presents them to the decode stage. It generates the stall request `id_wpcir` back to fetch and a bubble request toward EX. It flushes the wrong-path instruction when decode resolves a taken branch or jump, and keeps saturating stall and flush counters for the debug display.

---
 rtl/if_id_hazard_reg_pkg.sv | 28 ++
 rtl/if_id_hazard_reg_id_hazard_detect.sv | 70 +++++++
 rtl/if_id_hazard_reg.sv | 82 ++++++++
 tb/tb_if_id_hazard_reg.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/if_id_hazard_reg_pkg.sv
// Shared CPU defines: opcode/func encodings and the IF/ID action codes.
package if_id_hazard_reg_pkg;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (inst[5:0])
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;

  // Action taken by the IF/ID register at the last clock edge
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } id_state_e;

endpackage

// File: rtl/if_id_hazard_reg_id_hazard_detect.sv
// Combinational hazard detector: load-use and branch-operand hazards
// for the instruction currently held in ID.
module id_hazard_detect
  import if_id_hazard_reg_pkg::*;
(
  input  logic [31:0] id_inst,
  input  logic        id_valid,
  input  logic        ex_wreg,
  input  logic        ex_m2reg,
  input  logic [4:0]  ex_rn,
  input  logic        mem_wreg,
  input  logic        mem_m2reg,
  input  logic [4:0]  mem_rn,
  output logic        stall
);

  logic [5:0] op;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       reads_rs;
  logic       reads_rt;
  logic       is_branch;
  logic       unused_inst_low;
  logic       ex_hit;
  logic       ex_hit_any;
  logic       mem_hit_any;
  logic       load_use;
  logic       branch_haz;

  assign op              = id_inst[31:26];
  assign rs              = id_inst[25:21];
  assign rt              = id_inst[20:16];
  assign unused_inst_low = ^id_inst[15:0];

  // Decode which source registers the ID instruction actually reads.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    reads_rs  = 1'b0;
    reads_rt  = 1'b0;
    is_branch = 1'b0;
    case (op)
      OP_RTYPE, OP_SW: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: reads_rs = 1'b1;
      OP_BEQ, OP_BNE: begin
        reads_rs  = 1'b1;
        reads_rt  = 1'b1;
        is_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // Register 0 is hard-wired, so a zero destination never matches.
  assign ex_hit      = (ex_rn != 5'd0) &&
                       ((reads_rs && ex_rn == rs) || (reads_rt && ex_rn == rt));
  assign ex_hit_any  = (ex_rn != 5'd0) && (ex_rn == rs || ex_rn == rt);
  assign mem_hit_any = (mem_rn != 5'd0) && (mem_rn == rs || mem_rn == rt);

  // Branches compare in ID, so they wait on any EX writer and on a load in MEM.
  assign load_use   = id_valid && ex_wreg && ex_m2reg && ex_hit;
  assign branch_haz = id_valid && is_branch &&
                      ((ex_wreg && ex_hit_any) ||
                       (mem_wreg && mem_m2reg && mem_hit_any));

  assign stall = load_use || branch_haz;

endmodule

// File: rtl/if_id_hazard_reg.sv
// IF/ID pipeline register with stall/flush control and saturating
// event counters for the debug display.
module if_id_hazard_reg
  import if_id_hazard_reg_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc4,
  input  logic             ctrl_branch,
  input  logic             ex_wreg,
  input  logic             ex_m2reg,
  input  logic [4:0]       ex_rn,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic [4:0]       mem_rn,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc4,
  output logic             id_valid,
  output logic             id_wpcir,
  output logic             id_bubble,
  output logic [1:0]       id_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  id_state_e state_q;

  id_hazard_detect u_detect (
    .id_inst   (id_inst),
    .id_valid  (id_valid),
    .ex_wreg   (ex_wreg),
    .ex_m2reg  (ex_m2reg),
    .ex_rn     (ex_rn),
    .mem_wreg  (mem_wreg),
    .mem_m2reg (mem_m2reg),
    .mem_rn    (mem_rn),
    .stall     (id_wpcir)
  );

  assign id_bubble = id_wpcir || !id_valid;
  assign id_state  = state_q;

  // Pipeline register: stall beats flush beats normal load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_inst  <= NOP_INST;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
      state_q  <= ST_RUN;
    end else if (id_wpcir) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      state_q <= ST_STALL;
    end else if (ctrl_branch) begin
      id_inst  <= NOP_INST;
      id_pc4   <= if_pc4;
      id_valid <= 1'b0;
      state_q  <= ST_FLUSH;
    end else begin
      id_inst  <= if_inst;
      id_pc4   <= if_pc4;
      id_valid <= 1'b1;
      state_q  <= ST_RUN;
    end
  end

  // Saturating event counters; a flush is only counted when no stall overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (id_wpcir) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
    end else if (ctrl_branch) begin
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_hazard_reg.sv
// Directed self-checking bench for the IF/ID hazard register.
module tb_if_id_hazard_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_inst;
  logic [31:0] if_pc4;
  logic        ctrl_branch;
  logic        ex_wreg;
  logic        ex_m2reg;
  logic [4:0]  ex_rn;
  logic        mem_wreg;
  logic        mem_m2reg;
  logic [4:0]  mem_rn;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
  logic        id_wpcir;
  logic        id_bubble;
  logic [1:0]  id_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  int exp_stall;

  localparam logic [31:0] ADD_341 = 32'h00241820; // add $3,$1,$4
  localparam logic [31:0] ADD_300 = 32'h00001820; // add $3,$0,$0
  localparam logic [31:0] BEQ_10  = 32'h10200003; // beq $1,$0
  localparam logic [31:0] LW_12   = 32'h8C410000; // lw  $1,0($2)

  always #5 clk = ~clk;

  if_id_hazard_reg #(.NOP_INST(32'h00000000), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_inst     (if_inst),
    .if_pc4      (if_pc4),
    .ctrl_branch (ctrl_branch),
    .ex_wreg     (ex_wreg),
    .ex_m2reg    (ex_m2reg),
    .ex_rn       (ex_rn),
    .mem_wreg    (mem_wreg),
    .mem_m2reg   (mem_m2reg),
    .mem_rn      (mem_rn),
    .id_inst     (id_inst),
    .id_pc4      (id_pc4),
    .id_valid    (id_valid),
    .id_wpcir    (id_wpcir),
    .id_bubble   (id_bubble),
    .id_state    (id_state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic w, input logic m, input logic [4:0] rn);
    ex_wreg = w; ex_m2reg = m; ex_rn = rn;
  endtask

  task automatic set_mem(input logic w, input logic m, input logic [4:0] rn);
    mem_wreg = w; mem_m2reg = m; mem_rn = rn;
  endtask

  initial begin
    rst = 1'b0;
    if_inst = 32'h0; if_pc4 = 32'h0; ctrl_branch = 1'b0;
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b0, 1'b0, 5'd0);
    #1;

    // Reset state
    check("rst_inst",   id_inst,   32'h0);
    check("rst_pc4",    id_pc4,    32'h0);
    check("rst_valid",  id_valid,  32'h0);
    check("rst_state",  id_state,  32'd0);
    check("rst_wpcir",  id_wpcir,  32'h0);
    check("rst_bubble", id_bubble, 32'h1);
    check("rst_scnt",   stall_cnt, 32'h0);
    check("rst_fcnt",   flush_cnt, 32'h0);

    // First edge after release loads the add
    #6;
    rst = 1'b1;
    if_inst = ADD_341; if_pc4 = 32'd1;
    tick();
    check("load_inst",  id_inst,  ADD_341);
    check("load_pc4",   id_pc4,   32'd1);
    check("load_valid", id_valid, 32'h1);
    check("load_state", id_state, 32'd0);

    // Load-use: EX is lw $1
    set_ex(1'b1, 1'b1, 5'd1);
    if_inst = 32'h11111111; if_pc4 = 32'd2;
    #1;
    check("lu_wpcir",  id_wpcir,  32'h1);
    check("lu_bubble", id_bubble, 32'h1);
    tick();
    check("lu_hold_inst", id_inst,   ADD_341);
    check("lu_hold_pc4",  id_pc4,    32'd1);
    check("lu_state",     id_state,  32'd1);
    check("lu_scnt",      stall_cnt, 32'd1);

    // EX now a bubble, lw moved to MEM: add is not a branch, so no stall
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 1'b1, 5'd1);
    if_inst = BEQ_10; if_pc4 = 32'd2;
    #1;
    check("lu_clear_wpcir",  id_wpcir,  32'h0);
    check("lu_clear_bubble", id_bubble, 32'h0);
    tick();
    check("beq_inst",  id_inst,  BEQ_10);
    check("beq_state", id_state, 32'd0);

    // Load then branch: two stall cycles
    set_mem(1'b0, 1'b0, 5'd0);
    set_ex(1'b1, 1'b1, 5'd1);
    #1;
    check("lb1_wpcir", id_wpcir, 32'h1);
    tick();
    check("lb1_state", id_state,  32'd1);
    check("lb1_scnt",  stall_cnt, 32'd2);
    set_ex(1'b0, 1'b0, 5'd0);
    set_mem(1'b1, 1'b1, 5'd1);
    #1;
    check("lb2_wpcir", id_wpcir, 32'h1);
    tick();
    check("lb2_state", id_state,  32'd1);
    check("lb2_scnt",  stall_cnt, 32'd3);
    check("lb2_inst",  id_inst,   BEQ_10);
    set_mem(1'b0, 1'b0, 5'd0);
    if_inst = ADD_341; if_pc4 = 32'd3;
    #1;
    check("lb3_wpcir", id_wpcir, 32'h0);
    tick();
    check("lb3_state", id_state, 32'd0);
    check("lb3_inst",  id_inst,  ADD_341);

    // Flush: taken branch, no hazard
    ctrl_branch = 1'b1;
    if_inst = LW_12; if_pc4 = 32'h5;
    tick();
    check("fl_inst",  id_inst,   32'h0);
    check("fl_pc4",   id_pc4,    32'h5);
    check("fl_valid", id_valid,  32'h0);
    check("fl_state", id_state,  32'd2);
    check("fl_fcnt",  flush_cnt, 32'd1);
    check("fl_scnt",  stall_cnt, 32'd3);

    // Bubble never stalls, even with a load to $1 in EX
    ctrl_branch = 1'b0;
    set_ex(1'b1, 1'b1, 5'd1);
    #1;
    check("bub_wpcir",  id_wpcir,  32'h0);
    check("bub_bubble", id_bubble, 32'h1);

    // Simultaneous stall and flush: stall wins
    set_ex(1'b0, 1'b0, 5'd0);
    if_inst = ADD_341; if_pc4 = 32'd6;
    tick();
    set_ex(1'b1, 1'b1, 5'd4);
    ctrl_branch = 1'b1;
    if_pc4 = 32'd7;
    #1;
    check("sim_wpcir", id_wpcir, 32'h1);
    tick();
    check("sim_state", id_state,  32'd1);
    check("sim_fcnt",  flush_cnt, 32'd1);
    check("sim_scnt",  stall_cnt, 32'd4);
    check("sim_inst",  id_inst,   ADD_341);
    set_ex(1'b0, 1'b0, 5'd0);
    tick();
    check("sim_fl_state", id_state,  32'd2);
    check("sim_fl_fcnt",  flush_cnt, 32'd2);
    check("sim_fl_pc4",   id_pc4,    32'd7);
    check("sim_fl_inst",  id_inst,   32'h0);

    // No false hazard on register 0
    ctrl_branch = 1'b0;
    if_inst = ADD_300; if_pc4 = 32'd8;
    tick();
    set_ex(1'b1, 1'b1, 5'd0);
    #1;
    check("r0_wpcir", id_wpcir, 32'h0);
    tick();
    check("r0_state", id_state, 32'd0);

    // Saturation: hold a load-use stall until the counter reaches all-ones
    set_ex(1'b0, 1'b0, 5'd0);
    if_inst = ADD_341; if_pc4 = 32'd9;
    tick();
    set_ex(1'b1, 1'b1, 5'd1);
    exp_stall = 4;
    while (exp_stall < 32'hFFFF) begin
      tick();
      exp_stall++;
    end
    check("sat_reach", stall_cnt, 32'hFFFF);
    tick();
    check("sat_hold",  stall_cnt, 32'hFFFF);
    check("sat_inst",  id_inst,   ADD_341);

    // Reset mid-stall clears immediately, away from any edge
    #2;
    rst = 1'b0;
    #1;
    check("mrst_inst",  id_inst,   32'h0);
    check("mrst_valid", id_valid,  32'h0);
    check("mrst_wpcir", id_wpcir,  32'h0);
    check("mrst_scnt",  stall_cnt, 32'h0);
    check("mrst_fcnt",  flush_cnt, 32'h0);
    check("mrst_state", id_state,  32'd0);

    // First edge after release loads the fetch output
    set_ex(1'b0, 1'b0, 5'd0);
    if_inst = BEQ_10; if_pc4 = 32'd10;
    #1;
    rst = 1'b1;
    tick();
    check("rel_inst",  id_inst,  BEQ_10);
    check("rel_pc4",   id_pc4,   32'd10);
    check("rel_valid", id_valid, 32'h1);
    check("rel_state", id_state, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
